// File: rtl/audio_fifo_pkg.sv
// Shared types, defaults and helpers for the audio sample FIFO.
package audio_fifo_pkg;

   typedef logic [15:0] sample_t;

   localparam int unsigned DEF_WIDTH        = 16;
   localparam int unsigned DEF_DEPTH        = 512;
   localparam int unsigned DEF_AFULL_MARGIN = 4;
   localparam int unsigned DEF_AEMPTY_TH    = 4;

   // Level must represent 0..DEPTH inclusive, hence DEPTH+1 states.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (1-cycle latency).
module audio_fifo_ram
   import audio_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Read register holds its word while re is low; the FIFO uses it as the prefetch stage.
   always_ff @(posedge clk) begin
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/audio_stream_fifo.sv
// Single-clock FWFT audio sample FIFO with level and almost-full/empty status.
// Optional sticky overflow/underflow flags when AUDIO_FIFO_ERR_EN is defined.
module audio_stream_fifo
   import audio_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
   parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef AUDIO_FIFO_ERR_EN
   input  logic                          err_clr,
   output logic                          overflow,
   output logic                          underflow,
`endif
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              din,
   output logic                          full,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [WIDTH-1:0]              dout,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          almost_full,
   output logic                          almost_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = level_width(DEPTH);
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
   localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             ram_valid;
   logic [WIDTH-1:0] ram_rdata;
   logic [LW-1:0]    level_nxt;
   logic [LW-1:0]    ram_cnt;
   logic             wr_acc;
   logic             pop;
   logic             load_out;
   logic             rd_en;

   // Words still in RAM = level minus whatever sits in the prefetch and output stages.
   always_comb begin
      wr_acc    = wr_en && !full;
      pop       = rd_valid && rd_ready;
      load_out  = ram_valid && (!rd_valid || pop);
      ram_cnt   = level - LW'(ram_valid) - LW'(rd_valid);
      rd_en     = (ram_cnt != '0) && (!ram_valid || load_out);
      level_nxt = level;
      if (wr_acc && !pop)
         level_nxt = level + LW'(1);
      else if (!wr_acc && pop)
         level_nxt = level - LW'(1);
   end

   audio_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc && !rst),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (rd_en && !rst),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_valid    <= 1'b0;
         rd_valid     <= 1'b0;
         dout         <= '0;
         level        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         ram_valid <= rd_en || (ram_valid && !load_out);
         rd_valid  <= load_out || (rd_valid && !pop);
         if (load_out)
            dout <= ram_rdata;
         level        <= level_nxt;
         empty        <= (level_nxt == '0);
         full         <= (level_nxt == DEPTH_L);
         almost_full  <= (level_nxt >= AFULL_L);
         almost_empty <= (level_nxt <= AEMPTY_L);
      end
   end

`ifdef AUDIO_FIFO_ERR_EN
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_ready && !rd_valid && empty)
            underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_audio_stream_fifo.sv
// Directed self-checking bench for audio_stream_fifo at DEPTH=8 (AFULL_TH=4, AEMPTY_TH=2).
module tb_audio_stream_fifo;
   import audio_fifo_pkg::*;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_ready = 1'b0;
   sample_t    din = '0;
   logic       full, rd_valid, empty, almost_full, almost_empty;
   sample_t    dout;
   logic [3:0] level;
`ifdef AUDIO_FIFO_ERR_EN
   logic       err_clr = 1'b0;
   logic       overflow, underflow;
`endif

   int      errs = 0;
   int      checks = 0;
   sample_t q[$];
   int      lvl = 0;
   sample_t nd = '0;

   typedef struct {
      logic       wr;
      sample_t    d;
      logic       rdy;
      logic       ev;
      sample_t    ed;
      logic [3:0] el;
      logic       ee, ef, eae, eaf;
   } vec_t;
   vec_t tbl[13];

   audio_stream_fifo #(
      .WIDTH     (16),
      .DEPTH     (D),
      .AFULL_TH  (4),
      .AEMPTY_TH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef AUDIO_FIFO_ERR_EN
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow),
`endif
      .wr_en        (wr_en),
      .din          (din),
      .full         (full),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .dout         (dout),
      .empty        (empty),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("level", 32'(level), 32'(lvl));
      chk("empty", 32'(empty), 32'(lvl == 0));
      chk("full", 32'(full), 32'(lvl == D));
      chk("almost_full", 32'(almost_full), 32'(lvl >= 4));
      chk("almost_empty", 32'(almost_empty), 32'(lvl <= 2));
   endtask

   // One clock with scoreboard bookkeeping; din comes from nd, which advances on accepted writes.
   task automatic cyc(input logic w, input logic r);
      logic p, a;
      wr_en = w;
      din = nd;
      rd_ready = r;
      p = rd_valid && r;
      a = w && (lvl != D);
      if (p) begin
         if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL pop_order: got pop of 0x%0h, expected no data at %0t", dout, $time);
         end else begin
            chk("pop_data", 32'(dout), 32'(q[0]));
         end
      end
      @(posedge clk);
      #1;
      if (p && q.size() != 0)
         void'(q.pop_front());
      if (a) begin
         q.push_back(nd);
         nd = nd + 16'd1;
      end
      lvl = lvl + (a ? 1 : 0) - (p ? 1 : 0);
      check_status();
      wr_en = 1'b0;
      rd_ready = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (lvl == 0)
            break;
         cyc(1'b0, 1'b1);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_valid", 32'(rd_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //             wr    d         rdy   ev    ed        el     ee    ef    eae   eaf
      tbl[0]  = '{1'b1, 16'h00A5, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h00A5, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 16'h0006, 1'b0, 1'b1, 16'h0001, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 16'h0007, 1'b0, 1'b1, 16'h0001, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 16'h0008, 1'b0, 1'b1, 16'h0001, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 16'h0009, 1'b0, 1'b1, 16'h0001, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         wr_en = tbl[i].wr;
         din = tbl[i].d;
         rd_ready = tbl[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
         if (tbl[i].ev)
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].ed));
         chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].el));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].ee));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].ef));
         chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].eae));
         chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(tbl[i].eaf));
      end
      wr_en = 1'b0;
      rd_ready = 1'b0;

      // Full FIFO streaming: the 9th word was dropped, so 1..8 are resident.
      for (int i = 1; i <= 8; i++)
         q.push_back(sample_t'(i));
      lvl = 8;
      nd = 16'd100;
      for (int i = 0; i < 20; i++) begin
         chk("no_bubble", 32'(rd_valid), 32'd1);
         cyc(1'b1, 1'b1);
      end

      // Random stalls across several pointer wraps.
      nd = 16'd200;
      for (int i = 0; i < 90; i++) begin
         cyc((nd < 16'd230) && ($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0);
         chk("level_bound", 32'(level <= 4'd8), 32'd1);
      end
      drain();

      // Reset with words in flight, write and read ignored in the reset cycle.
      nd = 16'h0500;
      repeat (5) cyc(1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0);
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      rst = 1'b1;
      wr_en = 1'b1;
      din = 16'hDEAD;
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wr_en = 1'b0;
      rd_ready = 1'b0;
      q.delete();
      lvl = 0;
      check_status();
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      nd = 16'h1234;
      cyc(1'b1, 1'b0);
      chk("lat_valid_k1", 32'(rd_valid), 32'd0);
      cyc(1'b0, 1'b0);
      chk("lat_valid_k2", 32'(rd_valid), 32'd0);
      cyc(1'b0, 1'b0);
      chk("post_rst_valid", 32'(rd_valid), 32'd1);
      chk("post_rst_dout", 32'(dout), 32'h1234);
      drain();

`ifdef AUDIO_FIFO_ERR_EN
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_underflow", 32'(underflow), 32'd0);
      nd = 16'd1;
      repeat (8) cyc(1'b1, 1'b0);
      chk("ovf_quiet", 32'(overflow), 32'd0);
      cyc(1'b1, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      cyc(1'b0, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      drain();
      chk("udf_quiet", 32'(underflow), 32'd0);
      cyc(1'b0, 1'b1);
      chk("udf_set", 32'(underflow), 32'd1);
      err_clr = 1'b1;
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      rd_ready = 1'b0;
      chk("udf_clr_prio", 32'(underflow), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
